fetch_unit: RTL

Instruction fetch stage that produces the instruction stream consumed by `control`. It owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words in a 2-entry queue. It presents each instruction, with its 4-bit opcode field split out, to decode under a valid/ready handshake. It also handles branch/jump redirects from later stages and stops fetching permanently after a Halt (opcode 4'b1111) is consumed.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory, buffers responses in a 2-entry queue and hands them to
// decode under valid/ready. Handles redirects and stops permanently on Halt.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tag_q, tag_d;
    logic               pend_q, pend_d;
    logic               drop_q, drop_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [INSTR_W-1:0] e0_instr_q, e0_instr_d;
    logic [ADDR_W-1:0]  e0_pc_q, e0_pc_d;
    logic [INSTR_W-1:0] e1_instr_q, e1_instr_d;
    logic [ADDR_W-1:0]  e1_pc_q, e1_pc_d;

    logic run;
    logic redir_take;
    logic req;
    logic accept;
    logic pop;
    logic halt_pop;
    logic push;

    // Handshake strobes shared by the datapath and the FSM
    always_comb begin
        run        = (state_q == RUN);
        redir_take = redirect & run;
        req        = !rst & run & !redirect & !pend_q & (cnt_q != 2'd2);
        accept     = req & imem_gnt;
        pop        = (cnt_q != 2'd0) & instr_ready & !redirect;
        halt_pop   = pop & (e0_instr_q[INSTR_W-1 -: 4] == 4'hF);
        // A response is pushed unless it belongs to a discarded fetch or the
        // queue is being flushed this cycle.
        push       = imem_valid & !drop_q & !redir_take & !halt_pop & run;
    end

    // Next PC, outstanding-request tracking and queue contents
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;

        if (accept) begin
            pend_d = 1'b1;
            tag_d  = pc_q;
            pc_d   = pc_q + ADDR_W'(1);
        end
        if (imem_valid) begin
            pend_d = 1'b0;
            drop_d = 1'b0;
        end

        if (pop) begin
            e0_instr_d = e1_instr_q;
            e0_pc_d    = e1_pc_q;
        end
        if (push) begin
            // Push lands at the slot that is the tail after this cycle's pop
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
                e0_instr_d = imem_rdata;
                e0_pc_d    = tag_q;
            end else begin
                e1_instr_d = imem_rdata;
                e1_pc_d    = tag_q;
            end
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Flush; any request still in flight after this cycle must be discarded
        if (redir_take || halt_pop) begin
            cnt_d  = '0;
            drop_d = pend_d;
        end
        if (redir_take) begin
            pc_d = redirect_pc;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            e0_instr_q <= '0;
            e0_pc_q    <= '0;
            e1_instr_q <= '0;
            e1_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: consuming a Halt stops fetch until reset
    always_comb begin
        state_d = state_q;
        if (run && halt_pop) begin
            state_d = HALTED;
        end
    end

    // Outputs, all taken from registers except the request strobe
    always_comb begin
        imem_req    = req;
        imem_addr   = pc_q;
        instr_valid = (cnt_q != 2'd0);
        instr       = e0_instr_q;
        opcode      = e0_instr_q[INSTR_W-1 -: 4];
        instr_pc    = e0_pc_q;
        halted      = (state_q == HALTED);
    end

endmodule
